hidden_layer_scheduler: RTL and testbench



---
 rtl/hidden_layer_scheduler.sv | 100 ++++++++++
 tb/tb_hidden_layer_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hidden_layer_scheduler.sv
// hidden_layer_scheduler: steps (tile, input) pairs through the hidden-layer weight memory and MAC lanes
//   in : clk, rst (async, active-high), start, abort, tile_ready
//   out: input_sel, t (weight-memory address), mac_clr/mac_en/mac_last (MAC array control),
//        tile_valid/tile_idx (handoff to activation), busy, done
module hidden_layer_scheduler #(
    parameter int N_INPUTS = 62,
    parameter int N_TILES  = 2,
    parameter int SEL_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             tile_ready,
    output logic [SEL_W-1:0] input_sel,
    output logic             t,
    output logic             mac_clr,
    output logic             mac_en,
    output logic             mac_last,
    output logic             tile_valid,
    output logic             tile_idx,
    output logic             busy,
    output logic             done
);
    localparam int TW = (N_TILES > 1) ? $clog2(N_TILES) : 1;
    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, HANDOFF, DONE} state_t;
    state_t state;
    logic [TW-1:0] tc;
    assign t        = tc[0];
    assign tile_idx = tc[0];
    // Outputs are assigned alongside the state they belong to, so each one is a register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tc         <= '0;
            input_sel  <= '0;
            mac_clr    <= 1'b0;
            mac_en     <= 1'b0;
            mac_last   <= 1'b0;
            tile_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            mac_clr    <= 1'b0;
            mac_en     <= 1'b0;
            mac_last   <= 1'b0;
            tile_valid <= 1'b0;
            done       <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                tc        <= '0;
                input_sel <= '0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state     <= CLEAR;
                        tc        <= '0;
                        input_sel <= '0;
                        mac_clr   <= 1'b1;
                        busy      <= 1'b1;
                    end
                    CLEAR: begin
                        state     <= ACCUM;
                        input_sel <= '0;
                        mac_en    <= 1'b1;
                        mac_last  <= (N_INPUTS == 1);
                    end
                    ACCUM: if (input_sel == SEL_W'(N_INPUTS - 1)) begin
                        // input_sel stays on the last column while the tile is handed off
                        state      <= HANDOFF;
                        tile_valid <= 1'b1;
                    end else begin
                        input_sel <= input_sel + 1'b1;
                        mac_en    <= 1'b1;
                        mac_last  <= (input_sel == SEL_W'(N_INPUTS - 2));
                    end
                    HANDOFF: if (!tile_ready) begin
                        tile_valid <= 1'b1;
                    end else if (tc == TW'(N_TILES - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= CLEAR;
                        tc        <= tc + 1'b1;
                        input_sel <= '0;
                        mac_clr   <= 1'b1;
                    end
                    DONE: begin
                        state     <= IDLE;
                        tc        <= '0;
                        input_sel <= '0;
                        busy      <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hidden_layer_scheduler.sv
// tb_hidden_layer_scheduler: scoreboard bench with a behavioural weight memory and MAC array
module tb_hidden_layer_scheduler;
    localparam int NI = 62;
    localparam int NT = 2;
    localparam int LAT = NT * (NI + 2) + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        tile_ready = 1'b1;
    logic [31:0] input_sel;
    logic        t, mac_clr, mac_en, mac_last, tile_valid, tile_idx, busy, done;

    hidden_layer_scheduler #(.N_INPUTS(NI), .N_TILES(NT), .SEL_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .tile_ready(tile_ready),
        .input_sel(input_sel), .t(t), .mac_clr(mac_clr), .mac_en(mac_en),
        .mac_last(mac_last), .tile_valid(tile_valid), .tile_idx(tile_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    bit in_pass = 0;
    int exp_t, exp_sel, stalls;
    bit prev_tv, prev_last;
    int bp_mode = 0;
    int hold = 0;
    int w [0:10*NT*NI-1];
    int x [0:NI-1];
    int acc [0:9];
    int exp_acc_q[$];
    int done_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - start_cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Activation-stage backpressure: 0 always ready, 1 random, 2 stall `hold` cycles
    always @(posedge clk) begin
        #1;
        if (bp_mode == 1) tile_ready = ($urandom_range(0, 2) != 0);
        else if (bp_mode == 2 && tile_valid && hold > 0) begin
            tile_ready = 1'b0;
            hold--;
        end else tile_ready = 1'b1;
    end

    // Monitor: behavioural weight memory + MAC array, compared against the scoreboard
    always @(negedge clk) begin
        if (!rst && !in_pass) begin
            chk("idle_outputs_zero",
                {busy, mac_clr, mac_en, mac_last, tile_valid, tile_idx, done, t, input_sel}, 0);
        end else if (!rst) begin
            chk("busy", busy, 1);
            if (mac_clr) begin
                chk("clr_t", t, exp_t);
                chk("clr_no_en", mac_en, 0);
                for (int k = 0; k < 10; k++) acc[k] = 0;
                exp_sel = 0;
            end
            if (mac_en) begin
                chk("en_input_sel", input_sel, exp_sel);
                chk("en_mac_last", mac_last, exp_sel == NI - 1);
                if (input_sel < NI)
                    for (int k = 0; k < 10; k++)
                        acc[k] += w[(10 * t + k) * NI + int'(input_sel)] * x[input_sel];
                exp_sel++;
            end
            if (tile_valid) begin
                if (!prev_tv) chk("tv_after_last", prev_last, 1);
                chk("tv_input_sel", input_sel, NI - 1);
                chk("tv_t", t, exp_t);
                chk("tv_tile_idx", tile_idx, exp_t);
                chk("tv_no_en", mac_en, 0);
                if (tile_ready) begin
                    for (int k = 0; k < 10; k++) begin
                        if (exp_acc_q.size() == 0) chk("acc_queue_empty", 1, 0);
                        else chk($sformatf("acc_t%0d_n%0d", exp_t, k), acc[k], exp_acc_q.pop_front());
                    end
                    exp_t++;
                end else stalls++;
            end
            if (done) begin
                chk("done_expected", done_q.size() > 0, 1);
                if (done_q.size() > 0) void'(done_q.pop_front());
                chk("done_latency", cyc - start_cyc, LAT + stalls);
                chk("done_tiles", exp_t, NT);
                in_pass = 0;
            end
            prev_tv = tile_valid;
            prev_last = mac_last;
        end
    end

    task automatic flush();
        exp_acc_q.delete();
        done_q.delete();
        in_pass = 0;
    endtask

    task automatic start_pass();
        foreach (w[i]) w[i] = $urandom_range(0, 255);
        foreach (x[i]) x[i] = $urandom_range(0, 255);
        for (int tt = 0; tt < NT; tt++)
            for (int k = 0; k < 10; k++) begin
                int s = 0;
                for (int i = 0; i < NI; i++) s += w[(10 * tt + k) * NI + i] * x[i];
                exp_acc_q.push_back(s);
            end
        done_q.push_back(1);
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
        exp_t = 0;
        exp_sel = 0;
        stalls = 0;
        prev_tv = 0;
        prev_last = 0;
        @(posedge clk);
        #1 start = 1'b0;
        in_pass = 1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (in_pass && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (in_pass) begin
            chk("pass_timeout", 1, 0);
            flush();
        end
    endtask

    task automatic wait_cycle(input int c);
        while (cyc - start_cyc < c) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b1;
        #2 chk("reset_outputs_zero",
               {busy, mac_clr, mac_en, mac_last, tile_valid, tile_idx, done, t, input_sel}, 0);
        #8 rst = 1'b0;
        repeat (3) @(negedge clk);
        // nominal pass, always ready
        start_pass();
        wait_idle(400);
        repeat (5) @(negedge clk);
        // 5-cycle stall in the first handoff
        bp_mode = 2;
        hold = 5;
        start_pass();
        wait_idle(400);
        chk("stall_cycles", stalls, 5);
        bp_mode = 0;
        repeat (5) @(negedge clk);
        // start during ACCUM is ignored, no second pass follows
        start_pass();
        wait_cycle(30);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle(400);
        repeat (150) @(negedge clk);
        // abort at cycle 40
        start_pass();
        wait_cycle(40);
        chk("abort_input_sel", input_sel, 38);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        flush();
        repeat (10) @(negedge clk);
        start_pass();
        wait_idle(400);
        repeat (3) @(negedge clk);
        // asynchronous reset during the second tile's accumulation
        start_pass();
        wait_cycle(80);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset_zero",
               {busy, mac_clr, mac_en, mac_last, tile_valid, tile_idx, done, t, input_sel}, 0);
        flush();
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (20) @(negedge clk);
        // random weight/input sets with random backpressure
        bp_mode = 1;
        for (int p = 0; p < 100; p++) begin
            start_pass();
            wait_idle(2000);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        bp_mode = 0;
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
